// File: rtl/data_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : data_mem_arbiter                                                |
// | Purpose  : Two-requester arbiter in front of a single data memory port.   |
// |            IDLE arbitrates, BUSYn routes requester n straight through to  |
// |            the memory until mem_ready_i (completion) or until requester n |
// |            drops its request (abort).                                     |
// | Options  : DATA_MEM_ARBITER_RR_EN - round-robin on simultaneous requests; |
// |            undefined gives fixed priority to requester 0.                 |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module data_mem_arbiter (
  input  logic        clk_i,
  input  logic        rst_i,
  // requester 0
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wd_i,
  output logic [31:0] m0_rd_o,
  output logic        m0_ready_o,
  // requester 1
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wd_i,
  output logic [31:0] m1_rd_o,
  output logic        m1_ready_o,
  // data memory
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t state;
  logic   winner;     // 1 selects requester 1
  logic   busy0;
  logic   busy1;

`ifdef DATA_MEM_ARBITER_RR_EN
  logic   last_grant;

  // Round-robin: on a tie, favour the requester that was not served last.
  always_comb begin
    winner = m1_req_i & (~m0_req_i | ~last_grant);
  end
`else
  // Fixed priority: requester 1 only wins when requester 0 is silent.
  always_comb begin
    winner = m1_req_i & ~m0_req_i;
  end
`endif

  // Grant FSM: arbitrate in IDLE, leave BUSYn on completion or on abort.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
`ifdef DATA_MEM_ARBITER_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (m0_req_i || m1_req_i) begin
            state <= winner ? BUSY1 : BUSY0;
          end
        end
        BUSY0: begin
          if (!m0_req_i) begin
            // Abort: grant is released without counting as served.
            state <= IDLE;
          end else if (mem_ready_i) begin
            state <= IDLE;
`ifdef DATA_MEM_ARBITER_RR_EN
            last_grant <= 1'b0;
`endif
          end
        end
        BUSY1: begin
          if (!m1_req_i) begin
            state <= IDLE;
          end else if (mem_ready_i) begin
            state <= IDLE;
`ifdef DATA_MEM_ARBITER_RR_EN
            last_grant <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Grant qualifiers; reset masks them so every output is 0 while rst_i is high.
  always_comb begin
    busy0 = (state == BUSY0) && !rst_i;
    busy1 = (state == BUSY1) && !rst_i;
  end

  // Memory-side mux: the granted requester drives the memory port directly.
  always_comb begin
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_be_o   = 4'h0;
    mem_addr_o = 32'h0;
    mem_wd_o   = 32'h0;
    if (busy0) begin
      mem_req_o  = m0_req_i;
      mem_we_o   = m0_we_i;
      mem_be_o   = m0_be_i;
      mem_addr_o = m0_addr_i;
      mem_wd_o   = m0_wd_i;
    end else if (busy1) begin
      mem_req_o  = m1_req_i;
      mem_we_o   = m1_we_i;
      mem_be_o   = m1_be_i;
      mem_addr_o = m1_addr_i;
      mem_wd_o   = m1_wd_i;
    end
  end

  // Requester-side return path: ready only to the granted, still-requesting
  // master; read data is zero except during its ready pulse.
  always_comb begin
    m0_ready_o = busy0 && m0_req_i && mem_ready_i;
    m1_ready_o = busy1 && m1_req_i && mem_ready_i;
    m0_rd_o    = m0_ready_o ? mem_rd_i : 32'h0;
    m1_rd_o    = m1_ready_o ? mem_rd_i : 32'h0;
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_data_mem_arbiter                                             |
// | Purpose  : Directed, table-driven bench for data_mem_arbiter. Honours     |
// |            DATA_MEM_ARBITER_RR_EN for the contention expectations.        |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_data_mem_arbiter;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
  } mreq_t;

  typedef struct packed {
    mreq_t       mem;
    logic        rdy0;
    logic [31:0] rd0;
    logic        rdy1;
    logic [31:0] rd1;
  } out_t;

  typedef struct {
    string       name;
    logic        rst;
    mreq_t       m0;
    mreq_t       m1;
    logic [31:0] mrd;
    logic        mrdy;
    out_t        exp;
  } vec_t;

  localparam mreq_t NONE     = '0;
  localparam mreq_t RD0      = '{req:1'b1, we:1'b0, be:4'hF, addr:32'h0000_0010, wd:32'h0};
  localparam mreq_t WR1      = '{req:1'b1, we:1'b1, be:4'b0011, addr:32'h0000_0104, wd:32'h1234_5678};
  localparam mreq_t W0B      = '{req:1'b1, we:1'b1, be:4'hC, addr:32'h0000_0200, wd:32'hCAFE_F00D};
  localparam mreq_t W0B_DROP = '{req:1'b0, we:1'b1, be:4'hC, addr:32'h0000_0200, wd:32'hCAFE_F00D};
  localparam mreq_t RD3      = '{req:1'b1, we:1'b0, be:4'hF, addr:32'h0000_0300, wd:32'h0};

  logic        clk;
  logic        rst;
  mreq_t       m0;
  mreq_t       m1;
  logic [31:0] mem_rd;
  logic        mem_ready;
  logic [31:0] m0_rd, m1_rd;
  logic        m0_ready, m1_ready;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wd;

  int tests = 0;
  int fails = 0;
  vec_t vecs[$];

  data_mem_arbiter dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .m0_req_i   (m0.req),
    .m0_we_i    (m0.we),
    .m0_be_i    (m0.be),
    .m0_addr_i  (m0.addr),
    .m0_wd_i    (m0.wd),
    .m0_rd_o    (m0_rd),
    .m0_ready_o (m0_ready),
    .m1_req_i   (m1.req),
    .m1_we_i    (m1.we),
    .m1_be_i    (m1.be),
    .m1_addr_i  (m1.addr),
    .m1_wd_i    (m1.wd),
    .m1_rd_o    (m1_rd),
    .m1_ready_o (m1_ready),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_be_o   (mem_be),
    .mem_addr_o (mem_addr),
    .mem_wd_o   (mem_wd),
    .mem_rd_i   (mem_rd),
    .mem_ready_i(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t mk_out(mreq_t mem, logic r0, logic [31:0] d0,
                                  logic r1, logic [31:0] d1);
    out_t o;
    o.mem  = mem;
    o.rdy0 = r0;
    o.rd0  = d0;
    o.rdy1 = r1;
    o.rd1  = d1;
    return o;
  endfunction

  task automatic add(string name, logic r, mreq_t a, mreq_t b, logic [31:0] d,
                     logic rdy, out_t e);
    vec_t v;
    v.name = name;
    v.rst  = r;
    v.m0   = a;
    v.m1   = b;
    v.mrd  = d;
    v.mrdy = rdy;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  // One cycle: drive after the falling edge, compare 1 time unit later.
  task automatic step(string name, logic r, mreq_t a, mreq_t b, logic [31:0] d,
                      logic rdy, out_t e);
    out_t act;
    @(negedge clk);
    rst       = r;
    m0        = a;
    m1        = b;
    mem_rd    = d;
    mem_ready = rdy;
    #1;
    act.mem  = '{req:mem_req, we:mem_we, be:mem_be, addr:mem_addr, wd:mem_wd};
    act.rdy0 = m0_ready;
    act.rd0  = m0_rd;
    act.rdy1 = m1_ready;
    act.rd1  = m1_rd;
    tests++;
    if (act !== e) begin
      fails++;
      $display("FAIL %s: got req=%b we=%b be=%h addr=%h wd=%h rdy0=%b rd0=%h rdy1=%b rd1=%h ; need req=%b we=%b be=%h addr=%h wd=%h rdy0=%b rd0=%h rdy1=%b rd1=%h",
               name, act.mem.req, act.mem.we, act.mem.be, act.mem.addr, act.mem.wd,
               act.rdy0, act.rd0, act.rdy1, act.rd1,
               e.mem.req, e.mem.we, e.mem.be, e.mem.addr, e.mem.wd,
               e.rdy0, e.rd0, e.rdy1, e.rd1);
    end
  endtask

  initial begin
    out_t z;
    int   g;
    z = mk_out(NONE, 1'b0, 32'h0, 1'b0, 32'h0);

    rst = 1'b1; m0 = NONE; m1 = NONE; mem_rd = '0; mem_ready = 1'b0;

    // reset, stray ready while held in reset
    add("rst_a",    1, RD0, WR1, 32'h0, 0, z);
    add("rst_b",    1, RD0, WR1, 32'hFFFF_FFFF, 1, z);
    // single read, memory ready 3 cycles after mem_req_o rises
    add("rd_idle",  0, RD0, NONE, 32'h0, 0, z);
    add("rd_busy1", 0, RD0, NONE, 32'hDEAD_BEEF, 0, mk_out(RD0, 0, 0, 0, 0));
    add("rd_busy2", 0, RD0, NONE, 32'hDEAD_BEEF, 0, mk_out(RD0, 0, 0, 0, 0));
    add("rd_busy3", 0, RD0, NONE, 32'hDEAD_BEEF, 0, mk_out(RD0, 0, 0, 0, 0));
    add("rd_done",  0, RD0, NONE, 32'hDEAD_BEEF, 1, mk_out(RD0, 1, 32'hDEAD_BEEF, 0, 0));
    add("rd_after", 0, NONE, NONE, 32'hDEAD_BEEF, 0, z);
    // stray ready in IDLE
    add("stray_a",  0, NONE, NONE, 32'hFFFF_FFFF, 1, z);
    add("stray_b",  0, NONE, NONE, 32'hFFFF_FFFF, 1, z);
    // write routing for m1, m0 toggling while m1 holds the grant
    add("wr_idle",  0, NONE, WR1, 32'h0, 0, z);
    add("wr_busy",  0, W0B, WR1, 32'hFFFF_FFFF, 0, mk_out(WR1, 0, 0, 0, 0));
    add("wr_done",  0, W0B, WR1, 32'h0000_1111, 1, mk_out(WR1, 0, 0, 1, 32'h0000_1111));
    // abort: m0 drops req while granted
    add("ab_idle",  0, W0B, NONE, 32'h0, 0, z);
    add("ab_busy",  0, W0B, NONE, 32'h0, 0, mk_out(W0B, 0, 0, 0, 0));
    add("ab_drop",  0, W0B_DROP, NONE, 32'h0, 0, mk_out(W0B_DROP, 0, 0, 0, 0));
    add("ab_after", 0, NONE, NONE, 32'h0, 0, z);
    // reset mid-transfer, then both request
    add("rs_idle",  0, RD3, NONE, 32'h0, 0, z);
    add("rs_busy",  0, RD3, NONE, 32'h0, 0, mk_out(RD3, 0, 0, 0, 0));
    add("rs_assert",1, RD3, NONE, 32'h5555_5555, 1, z);
    add("rs_after", 0, RD3, WR1, 32'h0, 0, z);
    add("rs_win0",  0, RD3, WR1, 32'h1212_1212, 1, mk_out(RD3, 1, 32'h1212_1212, 0, 0));
    add("rs_idle1", 0, NONE, WR1, 32'h0, 0, z);
    add("rs_m1",    0, NONE, WR1, 32'h3434_3434, 1, mk_out(WR1, 0, 0, 1, 32'h3434_3434));
    add("end_idle", 0, NONE, NONE, 32'h0, 0, z);

    foreach (vecs[i]) begin
      step(vecs[i].name, vecs[i].rst, vecs[i].m0, vecs[i].m1, vecs[i].mrd,
           vecs[i].mrdy, vecs[i].exp);
    end

    // contention: both hold req, memory always ready, 4 transfers
    step("ct_reset", 1, NONE, NONE, 32'h0, 0, z);
    for (int t = 0; t < 4; t++) begin
`ifdef DATA_MEM_ARBITER_RR_EN
      g = t % 2;
`else
      g = 0;
`endif
      step($sformatf("ct_idle%0d", t), 0, RD0, WR1, 32'hC000_0000 + t, 1, z);
      if (g == 0)
        step($sformatf("ct_grant%0d_m0", t), 0, RD0, WR1, 32'hC000_0000 + t, 1,
             mk_out(RD0, 1, 32'hC000_0000 + t, 0, 0));
      else
        step($sformatf("ct_grant%0d_m1", t), 0, RD0, WR1, 32'hC000_0000 + t, 1,
             mk_out(WR1, 0, 0, 1, 32'hC000_0000 + t));
    end
    step("ct_end", 0, NONE, NONE, 32'h0, 0, z);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
